conv_vec_packer: RTL and testbench

- Producer-side front end for the convolution datapath.
- Accepts a serial stream of single `Conv::data_t` words over a valid/ready handshake.
- Assembles every LEN consecutive words into one `Conv::data_vector`.
- Presents each completed vector to the convolution core over a second valid/ready handshake, which lets the core consume whole vectors while upstream delivers one word per cycle.

---
 rtl/conv_vec_packer.sv | 140 ++++++++++++++
 tb/tb_conv_vec_packer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_vec_packer.sv
// Word-to-vector packer feeding the convolution core (LEN words per vector).
// Optional flush/pad of partial vectors: define CONV_PACK_FLUSH_EN.
package Conv;
    localparam int WIDTH = 64;
    localparam int LEN   = 4;
endpackage

module conv_vec_packer #(
    parameter int WIDTH = Conv::WIDTH,
    parameter int LEN   = Conv::LEN,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEN*WIDTH-1:0]   out_vec,
`ifdef CONV_PACK_FLUSH_EN
    input  logic                   flush,
`endif
    output logic [CNT_W-1:0]       vec_count
);

    localparam int IW = $clog2(LEN);
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [IW-1:0]               idx_q;
    logic [LEN-1:0][WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]            cnt_q;

    logic in_xfer;
    logic out_xfer;
    logic last_word;
    logic flush_go;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign last_word = (idx_q == LAST);

`ifdef CONV_PACK_FLUSH_EN
    // A flush that lands on the final word is just a normal completion.
    assign flush_go = (state_q == FILL) & flush
                    & ((idx_q != '0) | in_xfer)
                    & ~(in_xfer & last_word);
`else
    assign flush_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if ((in_xfer && last_word) || flush_go) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        unique case (state_q)
            FILL: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_xfer) begin
                        data_q[idx_q] <= in_data;
                    end
                    if (flush_go) begin
                        // Pad everything above the last written slot.
                        for (int i = 0; i < LEN; i++) begin
                            if ((i > int'(idx_q)) ||
                                (i == int'(idx_q) && !in_xfer)) begin
                                data_q[i] <= '0;
                            end
                        end
                        idx_q <= '0;
                    end else if (in_xfer) begin
                        idx_q <= last_word ? '0 : idx_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (in_xfer) begin
                            data_q[0] <= in_data;
                            idx_q     <= IW'(1);
                        end else begin
                            idx_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign out_vec   = data_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_conv_vec_packer.sv
// Scoreboard bench for conv_vec_packer; a second instance has a 4-bit counter.
// Flush scenarios are exercised when CONV_PACK_FLUSH_EN is defined.
module tb_conv_vec_packer;

    localparam int W  = 64;
    localparam int L  = 4;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   in_data = '0;
`ifdef CONV_PACK_FLUSH_EN
    logic           flush = 1'b0;
`endif

    logic             in_ready;
    logic             out_valid;
    logic [L*W-1:0]   out_vec;
    logic [CW-1:0]    vec_count;
    logic             in_ready_w;
    logic             out_valid_w;
    logic [L*W-1:0]   out_vec_w;
    logic [3:0]       vec_count_w;

    conv_vec_packer #(.WIDTH(W), .LEN(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
`ifdef CONV_PACK_FLUSH_EN
        .flush(flush),
`endif
        .vec_count(vec_count)
    );

    conv_vec_packer #(.WIDTH(W), .LEN(L), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_vec(out_vec_w),
`ifdef CONV_PACK_FLUSH_EN
        .flush(flush),
`endif
        .vec_count(vec_count_w)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int exp_cnt = 0;
    int m_idx = 0;
    logic [L-1:0][W-1:0] m_vec = '0;
    logic [L-1:0][W-1:0] sb[$];

    always @(posedge clk) cyc++;

    // Every out-transfer is checked against the oldest expected vector.
    always @(negedge clk) begin
        logic [L-1:0][W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected got=%h required=none", out_vec);
            end else begin
                e = sb.pop_front();
                if (out_vec !== e)
                    $display("FAIL sb_vec got=%h required=%h", out_vec, e);
                else
                    n_pass++;
            end
            exp_cnt++;
        end
    end

    task automatic send(input logic [W-1:0] w);
        bit acc = 0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        n_total++;
        if (!acc) begin
            $display("FAIL send_timeout word=%h in_ready=0 required=1", w);
        end else begin
            n_pass++;
            m_vec[m_idx] = w;
            m_idx++;
            if (m_idx == L) begin
                sb.push_back(m_vec);
                m_idx = 0;
            end
        end
    endtask

    task automatic model_flush();
        if (m_idx > 0) begin
            for (int i = m_idx; i < L; i++) m_vec[i] = '0;
            sb.push_back(m_vec);
            m_idx = 0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_total++;
        if (sb.size() != 0 || out_valid)
            $display("FAIL %s_drain pending=%0d out_valid=%b required 0/0",
                     tag, sb.size(), out_valid);
        else
            n_pass++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        m_idx = 0;
        m_vec = '0;
        exp_cnt = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset(2);
        n_total += 4;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b required=1", in_ready);
        else n_pass++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b required=0", out_valid);
        else n_pass++;
        if (out_vec !== '0) $display("FAIL rst_out_vec got=%h required=0", out_vec);
        else n_pass++;
        if (vec_count !== '0) $display("FAIL rst_vec_count got=%0d required=0", vec_count);
        else n_pass++;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(64'h11);
        send(64'h22);
        send(64'h33);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL basic_early_valid got=%b required=0", out_valid);
        else n_pass++;
        send(64'h44);
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL basic_latency got=%b required=1", out_valid);
        else n_pass++;
        drain("basic");
        n_total++;
        if (vec_count !== CW'(1)) $display("FAIL basic_count got=%0d required=1", vec_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [L-1:0][W-1:0] snap;
        int c0;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(W'(32'h100 + i));
        snap = sb[0];
        c0 = exp_cnt;
        in_valid = 1'b1;
        in_data  = 64'h55;
        repeat (5) begin
            @(negedge clk);
            n_total += 3;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b required=0", in_ready);
            else n_pass++;
            if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b required=1", out_valid);
            else n_pass++;
            if (out_vec !== snap) $display("FAIL bp_stable got=%h required=%h", out_vec, snap);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(64'h55);
        send(64'h66);
        send(64'h77);
        send(64'h88);
        drain("bp");
        n_total++;
        if (vec_count !== CW'(c0 + 2)) $display("FAIL bp_count got=%0d required=%0d", vec_count, c0 + 2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c0;
        int k0;
        out_ready = 1'b1;
        k0 = exp_cnt;
        c0 = cyc;
        for (int i = 1; i <= 12; i++) send(W'(i));
        n_total++;
        if (cyc - c0 != 12) $display("FAIL b2b_cycles got=%0d required=12", cyc - c0);
        else n_pass++;
        drain("b2b");
        n_total++;
        if (vec_count !== CW'(k0 + 3)) $display("FAIL b2b_count got=%0d required=%0d", vec_count, k0 + 3);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(64'hA);
        send(64'hB);
        do_reset(1);
        n_total += 2;
        if (out_valid !== 1'b0) $display("FAIL rmid_valid got=%b required=0", out_valid);
        else n_pass++;
        if (vec_count !== '0) $display("FAIL rmid_count0 got=%0d required=0", vec_count);
        else n_pass++;
        for (int i = 1; i <= 4; i++) send(W'(i));
        drain("rmid");
        n_total++;
        if (vec_count !== CW'(1)) $display("FAIL rmid_count got=%0d required=1", vec_count);
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        do_reset(1);
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < L; k++) send(W'(1000 + v * L + k));
            if (v == 14) begin
                drain("wrap15");
                n_total++;
                if (vec_count_w !== 4'd15) $display("FAIL wrap_15 got=%0d required=15", vec_count_w);
                else n_pass++;
            end
        end
        drain("wrap");
        n_total += 5;
        if (vec_count_w !== 4'd0) $display("FAIL wrap_zero got=%0d required=0", vec_count_w);
        else n_pass++;
        if (vec_count !== CW'(16)) $display("FAIL wrap_wide got=%0d required=16", vec_count);
        else n_pass++;
        if (out_vec_w !== m_vec) $display("FAIL wrap_stale got=%h required=%h", out_vec_w, m_vec);
        else n_pass++;
        if (in_ready_w !== 1'b1) $display("FAIL wrap_in_ready got=%b required=1", in_ready_w);
        else n_pass++;
        if (out_valid_w !== 1'b0) $display("FAIL wrap_out_valid got=%b required=0", out_valid_w);
        else n_pass++;
    endtask

`ifdef CONV_PACK_FLUSH_EN
    task automatic test_flush();
        do_reset(1);
        out_ready = 1'b1;
        send(64'h7);
        send(64'h8);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL flush_valid got=%b required=1", out_valid);
        else n_pass++;
        drain("flush");
        flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL flush_idle got=%b required=0", out_valid);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        send(64'h31);
        flush = 1'b1;
        send(64'h32);
        flush = 1'b0;
        model_flush();
        drain("flush_xfer");
        send(64'h41);
        send(64'h42);
        send(64'h43);
        flush = 1'b1;
        send(64'h44);
        flush = 1'b0;
        drain("flush_last");
        n_total++;
        if (vec_count !== CW'(3)) $display("FAIL flush_count got=%0d required=3", vec_count);
        else n_pass++;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
`ifdef CONV_PACK_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
